// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
// SEQ_DET_MASK_EN adds a per-bit don't-care mask to the configuration record.
package seq_det_pkg;

  // Configuration is held at the widest supported pattern size (32 bits);
  // the lenmask trims it to the live length.
  localparam int PAT_W     = 32;
  localparam int LEN_MAX_W = 6;

  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_e;

  typedef struct packed {
    logic [PAT_W-1:0]     pattern;
    logic [LEN_MAX_W-1:0] len;
    logic                 overlap;
`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0]     mask;
`endif
  } cfg_t;

  function automatic logic [PAT_W-1:0] len_to_mask(input logic [LEN_MAX_W-1:0] len);
    if (len >= LEN_MAX_W'(PAT_W)) return '1;
    return (PAT_W'(1) << len) - PAT_W'(1);
  endfunction

endpackage

// File: rtl/seq_det_counter.sv
// Saturating match counter; a clear coinciding with a match pulse leaves 1.
module seq_det_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= CNT_W'(inc_i);
    end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/param_seq_detector.sv
// Runtime-programmable serial bit-sequence detector with overlap control.
// Optional macro SEQ_DET_MASK_EN adds the cfg_mask don't-care input.
module param_seq_detector
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(8'b1011_0000),
  parameter int                 RST_LEN     = 4,
  localparam int                LEN_W       = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
`ifdef SEQ_DET_MASK_EN
  input  logic [MAX_LEN-1:0] cfg_mask,
`endif
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed
);

  localparam int RST_LEN_C = (RST_LEN < 1) ? 1 : ((RST_LEN > MAX_LEN) ? MAX_LEN : RST_LEN);
  // RST_PATTERN is written MSB-aligned; shift it down so bit [len-1] is the first bit.
  localparam logic [MAX_LEN-1:0] RST_PAT_LSB = RST_PATTERN >> (MAX_LEN - RST_LEN_C);

  function automatic logic [LEN_MAX_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == '0) return LEN_MAX_W'(1);
    if (l > LEN_W'(MAX_LEN)) return LEN_MAX_W'(MAX_LEN);
    return LEN_MAX_W'(l);
  endfunction

  cfg_t                 cfg_q, cfg_new, cfg_rst;
  // The oldest history bit is never part of a compare, so only MAX_LEN-1 are kept.
  logic [MAX_LEN-2:0]   history_q;
  logic [MAX_LEN-1:0]   window;
  logic [LEN_MAX_W-1:0] fill_q, fill_d;
  state_e               state_q;
  logic                 match_q;
  logic [PAT_W-1:0]     cmp_mask;
  logic                 can_cmp, hit;

  always_comb begin
    cfg_rst         = '0;
    cfg_rst.pattern = PAT_W'(RST_PAT_LSB);
    cfg_rst.len     = LEN_MAX_W'(RST_LEN_C);
    cfg_rst.overlap = 1'b1;
    cfg_new         = '0;
    cfg_new.pattern = PAT_W'(cfg_pattern);
    cfg_new.len     = clamp_len(cfg_len);
    cfg_new.overlap = cfg_overlap;
`ifdef SEQ_DET_MASK_EN
    cfg_rst.mask    = '1;
    cfg_new.mask    = PAT_W'(cfg_mask);
`endif
  end

  always_comb begin
    window   = {history_q, in_bit};
`ifdef SEQ_DET_MASK_EN
    cmp_mask = len_to_mask(cfg_q.len) & cfg_q.mask;
`else
    cmp_mask = len_to_mask(cfg_q.len);
`endif
    can_cmp  = (fill_q + LEN_MAX_W'(1)) >= cfg_q.len;
    hit      = can_cmp && (((PAT_W'(window) ^ cfg_q.pattern) & cmp_mask) == '0);
    if (hit) begin
      fill_d = cfg_q.overlap ? cfg_q.len : '0;
    end else if (fill_q < cfg_q.len) begin
      fill_d = fill_q + LEN_MAX_W'(1);
    end else begin
      fill_d = cfg_q.len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q     <= cfg_rst;
      history_q <= '0;
      fill_q    <= '0;
      state_q   <= FILL;
      match_q   <= 1'b0;
    end else if (cfg_load) begin
      cfg_q     <= cfg_new;
      history_q <= '0;
      fill_q    <= '0;
      state_q   <= FILL;
      match_q   <= 1'b0;
    end else if (in_valid) begin
      history_q <= window[MAX_LEN-2:0];
      fill_q    <= fill_d;
      state_q   <= (fill_d == cfg_q.len) ? ARMED : FILL;
      match_q   <= hit;
    end else begin
      match_q   <= 1'b0;
    end
  end

  // The counter consumes the registered pulse, so match_count follows match by a cycle.
  seq_det_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .inc_i  (match_q),
    .count_o(match_count)
  );

  assign match = match_q;
  assign armed = (state_q == ARMED);

endmodule
